io_output_bank: RTL and testbench
=================================

Name: io_output_bank

Overview:
- Parametrised memory-mapped output register bank driven by the CPU store path; successor to the fixed 4-port output register.
- Provides NUM_PORTS ports of DATA_W bits.
- Per-port write, set-bits, clear-bits and timed-pulse operations, selected by address region.
- Adds a registered readback path and per-port change strobes for downstream peripherals (LEDs, 7-seg, handshake lines).

Parameters:
- NUM_PORTS, 4, number of output ports; legal range 1..8.
- DATA_W, 32, width of each port; legal range 1..32. Only datain[DATA_W-1:0] is used.
- PULSE_CYC, 16, number of io_clk cycles a pulsed bit stays high; must be ≥1.

Ports:
- io_clk  in  1  sole clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- addr  in  32  byte address; only addr[7:2] is decoded.
- datain  in  32  write data.
- write_io_enable  in  1  write strobe, sampled on io_clk.
- read_io_enable  in  1  readback strobe, sampled on io_clk.
- out_ports  out  NUM_PORTS*DATA_W  port values; port i occupies bits [i*DATA_W +: DATA_W].
- out_changed  out  NUM_PORTS  one-cycle strobe: port value differs from its previous cycle value.
- rd_data  out  32  readback data, zero-extended.

Behaviour:
- Reset (clrn=0, asynchronous): all ports, pulse masks, pulse counters, out_changed and rd_data go to 0.
- Address decode:
  - addr[7:5] selects the op: 100 WRITE, 101 SET, 110 CLEAR, 111 PULSE; 0xx is not decoded.
  - addr[4:2] selects the port index.
  - Index ≥ NUM_PORTS, or op 0xx: write ignored, no state change.
  - WRITE addresses 0x80+4i are identical to the legacy 4-port map.
- Write latency: the op is applied on the io_clk edge where write_io_enable=1; the new value is visible on out_ports after that edge.
- WRITE: port = datain. Cancels any active pulse on that port (mask=0, counter=0).
- SET: port |= datain.
- CLEAR: port &= ~datain; mask &= ~datain.
- PULSE:
  - port |= datain; mask |= datain; counter = PULSE_CYC.
  - A re-pulse while active restarts the counter and accumulates the mask.
- Pulse timer, per port, one counter of width $clog2(PULSE_CYC+1):
  - Counter nonzero: decrement each cycle.
  - Edge where counter==1: port &= ~mask, mask=0, counter=0.
  - Result: pulsed bits are high for exactly PULSE_CYC cycles.
- Simultaneous expiry and bus op on the same port:
  - Expiry clear is applied first, then the bus op.
  - WRITE/SET/PULSE bits therefore survive.
  - PULSE reloads the counter with the new mask only (old mask already cleared).
- Bits outside DATA_W are never stored.
- out_changed[i]: registered, high for one cycle after any edge at which port i's value changed, including pulse expiry. A write of an identical value does not assert it.
- Readback:
  - read_io_enable=1 with a WRITE-region address and valid index: rd_data = port value one cycle later, held until the next read.
  - Read of any other address returns 0.
  - Read and write to the same port in the same cycle return the pre-write value.
- Reset mid-pulse: counter and mask cleared; no residual pulse after reset release.

Optional Feature:
- IO_OUT_READBACK_EN
  - Defined: readback path as above.
  - Undefined: rd_data is tied to 0, read_io_enable is ignored, and no readback mux is built.
  - Writes, pulses and out_changed are identical in both builds.

Decomposition:
- Package io_out_pkg:
  - op encodings OP_WRITE=3'b100, OP_SET=3'b101, OP_CLEAR=3'b110, OP_PULSE=3'b111.
  - MAX_PORTS=8.
  - function to extract the port index from addr.
- Sub-module io_pulse_timer:
  - one instance per port.
  - holds counter and mask.
  - inputs: load, load_mask, clr_mask, cancel.
  - outputs: expire strobe and current mask.
  - parameterised by DATA_W and PULSE_CYC.

Test Plan:
- Reset, then WRITE 0xDEADBEEF to 0x84 → out_ports port1=0xDEADBEEF after one edge; out_changed[1] pulses once; other ports stay 0.
- WRITE 0x0000FF00 to port0, SET 0x0F (0xA0), CLEAR 0x0F00 (0xC0) → port0 sequence 0xFF00, 0xFF0F, 0xF00F.
- PULSE_CYC=16: PULSE 0x1 to port2 (0xE8) → bit0 high exactly 16 cycles then 0; re-pulse 0x2 at cycle 10 → bit0 and bit1 both clear 16 cycles after the re-pulse.
- Pulse expiry coinciding with SET 0x1 on the same port → bit0 remains 1 after expiry; out_changed not asserted that cycle.
- NUM_PORTS=4: WRITE to 0x90 (index 4) and to 0x40 → no output change; read 0x90 → rd_data=0.
- Readback build: WRITE 0x55 to port3, then read and write 0xAA to 0x8C in the same cycle → rd_data=0x55 next cycle, port3=0xAA; assert clrn mid-pulse → all outputs 0 and stay 0 after release.

Source files
------------

// File: rtl/io_out_pkg.sv
// Shared encodings and address helpers for the io_output_bank register map.
package io_out_pkg;

  localparam logic [2:0] OP_WRITE = 3'b100;
  localparam logic [2:0] OP_SET   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_PULSE = 3'b111;

  localparam int MAX_PORTS = 8;

  function automatic logic [2:0] op_of(input logic [31:0] a);
    return a[7:5];
  endfunction

  function automatic logic [2:0] port_idx(input logic [31:0] a);
    return a[4:2];
  endfunction

endpackage

// File: rtl/io_pulse_timer.sv
// Per-port pulse timer: tracks which bits were pulsed and when they must drop.
module io_pulse_timer #(
  parameter int DATA_W    = 32,
  parameter int PULSE_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_mask_i,
  input  logic [DATA_W-1:0] clr_mask_i,
  input  logic              cancel_i,
  output logic              expire_o,
  output logic [DATA_W-1:0] mask_o
);

  localparam int CW = $clog2(PULSE_CYC + 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mask_q, mask_d;

  assign expire_o = (cnt_q == CW'(1));
  assign mask_o   = mask_q;

  // Expiry is resolved before the bus op so a same-edge op always wins.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (expire_o) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (cancel_i) begin
      cnt_d  = '0;
      mask_d = '0;
    end
    mask_d = mask_d & ~clr_mask_i;
    if (load_i) begin
      mask_d = mask_d | load_mask_i;
      cnt_d  = CW'(PULSE_CYC);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output register bank with set/clear/pulse ops and change strobes.
// Define IO_OUT_READBACK_EN to build the registered readback path on rd_data.
module io_output_bank
  import io_out_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int PULSE_CYC = 16
) (
  input  logic                        io_clk,
  input  logic                        clrn,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 datain,
  input  logic                        write_io_enable,
  input  logic                        read_io_enable,
  output logic [NUM_PORTS*DATA_W-1:0] out_ports,
  output logic [NUM_PORTS-1:0]        out_changed,
  output logic [31:0]                 rd_data
);

  localparam int IDX_LIMIT = (NUM_PORTS < MAX_PORTS) ? NUM_PORTS : MAX_PORTS;

  logic [2:0]        op, idx;
  logic              idx_ok;
  logic [DATA_W-1:0] wdat;
  logic [NUM_PORTS-1:0] sel, expire, chg_d, chg_q;
  logic [DATA_W-1:0] port_q [NUM_PORTS];
  logic [DATA_W-1:0] port_d [NUM_PORTS];
  logic [DATA_W-1:0] tmask  [NUM_PORTS];
  logic              unused_bits;

  assign op          = op_of(addr);
  assign idx         = port_idx(addr);
  assign idx_ok      = int'(idx) < IDX_LIMIT;
  assign wdat        = datain[DATA_W-1:0];
  assign out_changed = chg_q;
  assign unused_bits = ^{addr[31:8], addr[1:0], datain};

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign sel[gi] = write_io_enable && op[2] && idx_ok && (int'(idx) == gi);
    assign out_ports[gi*DATA_W +: DATA_W] = port_q[gi];

    io_pulse_timer #(
      .DATA_W   (DATA_W),
      .PULSE_CYC(PULSE_CYC)
    ) u_timer (
      .clk_i      (io_clk),
      .rst_ni     (clrn),
      .load_i     (sel[gi] && (op == OP_PULSE)),
      .load_mask_i(wdat),
      .clr_mask_i ((sel[gi] && (op == OP_CLEAR)) ? wdat : '0),
      .cancel_i   (sel[gi] && (op == OP_WRITE)),
      .expire_o   (expire[gi]),
      .mask_o     (tmask[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_d[i] = port_q[i];
      if (expire[i]) port_d[i] = port_d[i] & ~tmask[i];
      if (sel[i]) begin
        case (op)
          OP_WRITE: port_d[i] = wdat;
          OP_SET:   port_d[i] = port_d[i] | wdat;
          OP_CLEAR: port_d[i] = port_d[i] & ~wdat;
          default:  port_d[i] = port_d[i] | wdat;
        endcase
      end
      chg_d[i] = (port_d[i] != port_q[i]);
    end
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= '0;
      chg_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= port_d[i];
      chg_q <= chg_d;
    end
  end

`ifdef IO_OUT_READBACK_EN
  logic [31:0] rd_q, rd_d;

  // Readback samples port_q, so a same-cycle write returns the old value.
  always_comb begin
    rd_d = rd_q;
    if (read_io_enable) begin
      rd_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((op == OP_WRITE) && idx_ok && (int'(idx) == i)) rd_d[DATA_W-1:0] = port_q[i];
      end
    end
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rd_data = rd_q;
`else
  logic unused_rd;
  assign unused_rd = read_io_enable;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_io_output_bank.sv
// Scoreboard bench for io_output_bank (default parameters: 4 ports x 32 bits, 16-cycle pulse).
module tb_io_output_bank;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int PW = NP * DW;

  logic          io_clk = 1'b0;
  logic          clrn = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   datain = '0;
  logic          write_io_enable = 1'b0;
  logic          read_io_enable = 1'b0;
  logic [PW-1:0] out_ports;
  logic [NP-1:0] out_changed;
  logic [31:0]   rd_data;

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] e;

  io_output_bank #(.NUM_PORTS(NP), .DATA_W(DW), .PULSE_CYC(16)) dut (
    .io_clk         (io_clk),
    .clrn           (clrn),
    .addr           (addr),
    .datain         (datain),
    .write_io_enable(write_io_enable),
    .read_io_enable (read_io_enable),
    .out_ports      (out_ports),
    .out_changed    (out_changed),
    .rd_data        (rd_data)
  );

  always #5 io_clk = ~io_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pv(input int i);
    return out_ports[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge io_clk);
    addr = a; datain = d; write_io_enable = 1'b1;
    @(posedge io_clk);
    #1;
    write_io_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge io_clk);
    addr = a; read_io_enable = 1'b1;
    @(posedge io_clk);
    #1;
    read_io_enable = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    #12;
    checks++;
    if (out_ports !== '0) begin failures++; $display("FAIL reset_ports got=%h exp=0", out_ports); end
    checks++;
    if (out_changed !== '0) begin failures++; $display("FAIL reset_changed got=%b exp=0", out_changed); end
    checks++;
    if (rd_data !== '0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    @(negedge io_clk);
    clrn = 1'b1;
  endtask

  task automatic test_write();
    exp_q.push_back({32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    wr(32'h84, 32'hDEADBEEF);
    e = exp_q.pop_front();
    checks++;
    if (out_ports !== e) begin failures++; $display("FAIL write_port1 got=%h exp=%h", out_ports, e); end
    checks++;
    if (out_changed !== 4'b0010) begin failures++; $display("FAIL write_changed got=%b exp=0010", out_changed); end
    tick();
    checks++;
    if (out_changed !== 4'b0000) begin failures++; $display("FAIL write_changed_once got=%b exp=0000", out_changed); end
    wr(32'h84, 32'hDEADBEEF);
    checks++;
    if (out_changed !== 4'b0000) begin failures++; $display("FAIL same_value_changed got=%b exp=0000", out_changed); end
  endtask

  task automatic test_set_clear();
    logic [31:0] a [3];
    logic [31:0] d [3];
    a[0] = 32'h80; d[0] = 32'h0000FF00;
    a[1] = 32'hA0; d[1] = 32'h0000000F;
    a[2] = 32'hC0; d[2] = 32'h00000F00;
    exp_q.push_back(PW'(32'h0000FF00));
    exp_q.push_back(PW'(32'h0000FF0F));
    exp_q.push_back(PW'(32'h0000F00F));
    for (int k = 0; k < 3; k++) begin
      wr(a[k], d[k]);
      e = exp_q.pop_front();
      checks++;
      if (pv(0) !== e[31:0]) begin failures++; $display("FAIL set_clear_step%0d got=%h exp=%h", k, pv(0), e[31:0]); end
    end
  endtask

  task automatic test_pulse();
    wr(32'hE8, 32'h1);
    for (int k = 1; k <= 16; k++) exp_q.push_back(PW'((k < 16) ? 32'h1 : 32'h0));
    checks++;
    if (pv(2) !== 32'h1) begin failures++; $display("FAIL pulse_start got=%h exp=1", pv(2)); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pv(2) !== e[31:0]) begin failures++; $display("FAIL pulse_cycle%0d got=%h exp=%h", k, pv(2), e[31:0]); end
    end
    checks++;
    if (out_changed !== 4'b0100) begin failures++; $display("FAIL pulse_expiry_changed got=%b exp=0100", out_changed); end
    // re-pulse at cycle 10 extends and accumulates
    wr(32'hE8, 32'h1);
    for (int k = 1; k <= 9; k++) tick();
    wr(32'hE8, 32'h2);
    exp_q.push_back(PW'(32'h3));
    exp_q.push_back(PW'(32'h0));
    for (int k = 1; k <= 15; k++) tick();
    e = exp_q.pop_front();
    checks++;
    if (pv(2) !== e[31:0]) begin failures++; $display("FAIL repulse_before got=%h exp=%h", pv(2), e[31:0]); end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pv(2) !== e[31:0]) begin failures++; $display("FAIL repulse_expire got=%h exp=%h", pv(2), e[31:0]); end
  endtask

  task automatic test_expiry_with_set();
    wr(32'hE8, 32'h1);
    for (int k = 1; k <= 15; k++) tick();
    exp_q.push_back(PW'(32'h1));
    wr(32'hA8, 32'h1);
    e = exp_q.pop_front();
    checks++;
    if (pv(2) !== e[31:0]) begin failures++; $display("FAIL expiry_set_port got=%h exp=%h", pv(2), e[31:0]); end
    checks++;
    if (out_changed !== 4'b0000) begin failures++; $display("FAIL expiry_set_changed got=%b exp=0000", out_changed); end
    tick();
    checks++;
    if (pv(2) !== 32'h1) begin failures++; $display("FAIL expiry_set_hold got=%h exp=1", pv(2)); end
    wr(32'h88, 32'h0);
  endtask

  task automatic test_invalid();
    logic [PW-1:0] snap;
    snap = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0000F00F};
    exp_q.push_back(snap);
    exp_q.push_back(snap);
    wr(32'h90, 32'hFFFFFFFF);
    e = exp_q.pop_front();
    checks++;
    if (out_ports !== e || out_changed !== '0) begin
      failures++; $display("FAIL invalid_index got=%h/%b exp=%h/0", out_ports, out_changed, e);
    end
    wr(32'h40, 32'hFFFFFFFF);
    e = exp_q.pop_front();
    checks++;
    if (out_ports !== e || out_changed !== '0) begin
      failures++; $display("FAIL invalid_op got=%h/%b exp=%h/0", out_ports, out_changed, e);
    end
    rd(32'h90);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL read_invalid got=%h exp=0", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
`ifdef IO_OUT_READBACK_EN
    exp_rd = 32'h55;
`else
    exp_rd = 32'h0;
`endif
    wr(32'h8C, 32'h55);
    exp_q.push_back({32'hAA, 32'h0, 32'hDEADBEEF, 32'h0000F00F});
    @(negedge io_clk);
    addr = 32'h8C; datain = 32'hAA; write_io_enable = 1'b1; read_io_enable = 1'b1;
    @(posedge io_clk);
    #1;
    write_io_enable = 1'b0; read_io_enable = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_ports !== e) begin failures++; $display("FAIL rw_port3 got=%h exp=%h", out_ports, e); end
    checks++;
    if (rd_data !== exp_rd) begin failures++; $display("FAIL rw_readback got=%h exp=%h", rd_data, exp_rd); end
    tick();
    checks++;
    if (rd_data !== exp_rd) begin failures++; $display("FAIL readback_hold got=%h exp=%h", rd_data, exp_rd); end
    rd(32'h40);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL read_unmapped got=%h exp=0", rd_data); end
  endtask

  task automatic test_reset_mid_pulse();
    wr(32'h8C, 32'h77);
    wr(32'hE0, 32'h000000F0);
    checks++;
    if (pv(0) !== 32'h0000F0FF) begin failures++; $display("FAIL pulse_port0 got=%h exp=0000f0ff", pv(0)); end
    rd(32'h8C);
    tick();
    #2 clrn = 1'b0;
    #1;
    checks++;
    if (out_ports !== '0 || out_changed !== '0 || rd_data !== '0) begin
      failures++; $display("FAIL async_reset got=%h/%b/%h exp=0/0/0", out_ports, out_changed, rd_data);
    end
    @(negedge io_clk);
    clrn = 1'b1;
    for (int k = 0; k < 20; k++) exp_q.push_back('0);
    for (int k = 0; k < 20; k++) begin
      tick();
      e = exp_q.pop_front();
      if (out_ports !== e || out_changed !== '0) begin
        failures++; $display("FAIL post_reset_cycle%0d got=%h/%b exp=0/0", k, out_ports, out_changed);
      end
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_clear();
    test_pulse();
    test_expiry_with_set();
    test_invalid();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
